// File: rtl/lcd_mode_sequencer_pkg.sv
// Shared LCD timing types and default geometry for the whizgraphics renderer.
package lcd_mode_sequencer_pkg;

    localparam int LCD_LINES         = 144;
    localparam int LCD_LINEWIDTH     = 160;

    localparam int LCD_DOTS_PER_LINE = 456;
    localparam int LCD_OAM_DOTS      = 80;
    localparam int LCD_XFER_DOTS     = 172;
    localparam int LCD_VISIBLE_LINES = LCD_LINES;
    localparam int LCD_TOTAL_LINES   = 154;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } LcdMode;

endpackage

// File: rtl/lcd_mode_sequencer_if.sv
// Register-side and renderer-side signals of the LCD mode sequencer.
interface lcd_mode_sequencer_if;
    import lcd_mode_sequencer_pkg::*;

    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_int_en;
    logic       drawline;
    logic [7:0] ly;
    LcdMode     mode;
    logic       lyc_match;
    logic       vblank_irq;
    logic       stat_irq;
    logic       frame_done;
    logic       vram_cpu_ok;
    logic       oam_cpu_ok;

    modport master (
        input  lcd_enable, lyc, stat_int_en,
        output drawline, ly, mode, lyc_match, vblank_irq, stat_irq,
               frame_done, vram_cpu_ok, oam_cpu_ok
    );

    modport slave (
        output lcd_enable, lyc, stat_int_en,
        input  drawline, ly, mode, lyc_match, vblank_irq, stat_irq,
               frame_done, vram_cpu_ok, oam_cpu_ok
    );
endinterface

// File: rtl/lcd_mode_sequencer_stat_irq.sv
// STAT interrupt line: OR of enabled sources, rising-edge pulse, forced low while disabled.
module lcd_stat_irq
    import lcd_mode_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  LcdMode     mode_next,
    input  logic       lyc_match_next,
    input  logic [3:0] stat_int_en,
    output logic       stat_irq
);
    logic stat_line_s;
    logic stat_line_r;
    logic stat_irq_r;

    // Combined STAT source line for the upcoming cycle
    always_comb begin
        stat_line_s = 1'b0;
        if (enable) begin
            stat_line_s = (stat_int_en[0] & (mode_next == MODE_HBLANK))
                        | (stat_int_en[1] & (mode_next == MODE_VBLANK))
                        | (stat_int_en[2] & (mode_next == MODE_OAM))
                        | (stat_int_en[3] & lyc_match_next);
        end else begin
            stat_line_s = 1'b0;
        end
    end

    // Edge detector: sources overlapping with no low gap produce a single pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_line_r <= 1'b0;
            stat_irq_r  <= 1'b0;
        end else begin
            stat_line_r <= stat_line_s;
            stat_irq_r  <= stat_line_s & ~stat_line_r;
        end
    end

    assign stat_irq = stat_irq_r;
endmodule

// File: rtl/lcd_mode_sequencer.sv
// Dot/line timing controller: dot and LY counters, mode decode, strobes and CPU access grants.
module lcd_mode_sequencer
    import lcd_mode_sequencer_pkg::*;
#(
    parameter int DOTS_PER_LINE = LCD_DOTS_PER_LINE,
    parameter int OAM_DOTS      = LCD_OAM_DOTS,
    parameter int XFER_DOTS     = LCD_XFER_DOTS,
    parameter int VISIBLE_LINES = LCD_VISIBLE_LINES,
    parameter int TOTAL_LINES   = LCD_TOTAL_LINES
) (
    input  logic                clk,
    input  logic                reset,
    lcd_mode_sequencer_if.master bus
);
    localparam int DOT_W = $clog2(DOTS_PER_LINE);
    localparam logic [DOT_W-1:0] DOT_ZERO = {DOT_W{1'b0}};
    localparam logic [DOT_W-1:0] DOT_ONE  = DOT_W'(1'b1);
    localparam logic [DOT_W-1:0] DOT_LAST = DOT_W'(DOTS_PER_LINE - 1);
    localparam logic [DOT_W-1:0] OAM_END  = DOT_W'(OAM_DOTS);
    localparam logic [DOT_W-1:0] XFER_END = DOT_W'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0]       LY_VIS   = 8'(VISIBLE_LINES);
    localparam logic [7:0]       LY_LAST  = 8'(TOTAL_LINES - 1);

    logic             running_r;
    logic [DOT_W-1:0] dot_r;
    logic [7:0]       ly_r;
    LcdMode           mode_r;
    logic             drawline_r;
    logic             lyc_match_r;
    logic             vblank_irq_r;
    logic             frame_done_r;
    logic             vram_ok_r;
    logic             oam_ok_r;

    logic [DOT_W-1:0] dot_next_s;
    logic [7:0]       ly_next_s;
    LcdMode           mode_next_s;
    logic             lyc_match_next_s;

    // Next dot/ly; a fresh enable (or a disabled cycle) parks at line 0 dot 0
    always_comb begin
        dot_next_s = DOT_ZERO;
        ly_next_s  = 8'd0;
        if (!bus.lcd_enable || !running_r) begin
            dot_next_s = DOT_ZERO;
            ly_next_s  = 8'd0;
        end else if (dot_r == DOT_LAST) begin
            dot_next_s = DOT_ZERO;
            if (ly_r == LY_LAST) begin
                ly_next_s = 8'd0;
            end else begin
                ly_next_s = ly_r + 8'd1;
            end
        end else begin
            dot_next_s = dot_r + DOT_ONE;
            ly_next_s  = ly_r;
        end
    end

    // Mode and LYC compare for the position being entered
    always_comb begin
        mode_next_s      = MODE_HBLANK;
        lyc_match_next_s = 1'b0;
        if (!bus.lcd_enable) begin
            mode_next_s      = MODE_HBLANK;
            lyc_match_next_s = 1'b0;
        end else begin
            lyc_match_next_s = (ly_next_s == bus.lyc);
            if (ly_next_s >= LY_VIS) begin
                mode_next_s = MODE_VBLANK;
            end else if (dot_next_s < OAM_END) begin
                mode_next_s = MODE_OAM;
            end else if (dot_next_s < XFER_END) begin
                mode_next_s = MODE_XFER;
            end else begin
                mode_next_s = MODE_HBLANK;
            end
        end
    end

    // Counter, mode and output registers, all updated together
    always_ff @(posedge clk) begin
        if (reset) begin
            running_r    <= 1'b0;
            dot_r        <= DOT_ZERO;
            ly_r         <= 8'd0;
            mode_r       <= MODE_HBLANK;
            drawline_r   <= 1'b0;
            lyc_match_r  <= 1'b0;
            vblank_irq_r <= 1'b0;
            frame_done_r <= 1'b0;
            vram_ok_r    <= 1'b1;
            oam_ok_r     <= 1'b1;
        end else begin
            running_r    <= bus.lcd_enable;
            dot_r        <= dot_next_s;
            ly_r         <= ly_next_s;
            mode_r       <= mode_next_s;
            lyc_match_r  <= lyc_match_next_s;
            drawline_r   <= bus.lcd_enable && (ly_next_s < LY_VIS) && (dot_next_s == OAM_END);
            vblank_irq_r <= bus.lcd_enable && (ly_next_s == LY_VIS) && (dot_next_s == DOT_ZERO);
            frame_done_r <= bus.lcd_enable && (ly_next_s == LY_LAST) && (dot_next_s == DOT_LAST);
            vram_ok_r    <= (mode_next_s != MODE_XFER);
            oam_ok_r     <= !((mode_next_s == MODE_OAM) || (mode_next_s == MODE_XFER));
        end
    end

    lcd_stat_irq u_stat_irq (
        .clk            (clk),
        .reset          (reset),
        .enable         (bus.lcd_enable),
        .mode_next      (mode_next_s),
        .lyc_match_next (lyc_match_next_s),
        .stat_int_en    (bus.stat_int_en),
        .stat_irq       (bus.stat_irq)
    );

    assign bus.drawline    = drawline_r;
    assign bus.ly          = ly_r;
    assign bus.mode        = mode_r;
    assign bus.lyc_match   = lyc_match_r;
    assign bus.vblank_irq  = vblank_irq_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.vram_cpu_ok = vram_ok_r;
    assign bus.oam_cpu_ok  = oam_ok_r;
endmodule

// File: tb/tb_lcd_mode_sequencer.sv
// Directed bench for lcd_mode_sequencer; line count shortened so whole frames fit the cycle budget.
module tb_lcd_mode_sequencer;
    import lcd_mode_sequencer_pkg::*;

    localparam int T_DOTS  = 456;
    localparam int T_OAM   = 80;
    localparam int T_XFER  = 172;
    localparam int T_VIS   = 16;
    localparam int T_TOTAL = 20;

    // {drawline, ly, mode, lyc_match, vblank_irq, stat_irq, frame_done, vram_ok, oam_ok}
    localparam logic [16:0] IDLE_V = {1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    logic clk;
    logic reset;
    lcd_mode_sequencer_if bus ();

    lcd_mode_sequencer #(
        .DOTS_PER_LINE (T_DOTS),
        .OAM_DOTS      (T_OAM),
        .XFER_DOTS     (T_XFER),
        .VISIBLE_LINES (T_VIS),
        .TOTAL_LINES   (T_TOTAL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp;
    int n_err;
    int m_dot;
    int m_ly;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] obs_vec();
        return {bus.drawline, bus.ly, bus.mode, bus.lyc_match, bus.vblank_irq,
                bus.stat_irq, bus.frame_done, bus.vram_cpu_ok, bus.oam_cpu_ok};
    endfunction

    function automatic logic [16:0] model_vec(input int d, input int l, input logic lm, input logic si);
        logic [1:0] md;
        md = (l >= T_VIS) ? 2'd1 : (d < T_OAM) ? 2'd2 : (d < T_OAM + T_XFER) ? 2'd3 : 2'd0;
        return {(d == T_OAM && l < T_VIS), 8'(l), md, lm, (l == T_VIS && d == 0), si,
                (l == T_TOTAL - 1 && d == T_DOTS - 1), (md != 2'd3), !(md == 2'd2 || md == 2'd3)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_model();
        step();
        m_dot++;
        if (m_dot == T_DOTS) begin
            m_dot = 0;
            m_ly  = (m_ly == T_TOTAL - 1) ? 0 : m_ly + 1;
        end
    endtask

    task automatic restart();
        bus.lcd_enable = 1'b0;
        step();
        bus.lcd_enable = 1'b1;
        step();
        m_dot = 0;
        m_ly  = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.lcd_enable = 1'b1;
        bus.lyc = 8'd0;
        bus.stat_int_en = 4'hF;
        step();
        step();
        n_cmp++;
        if (obs_vec() !== IDLE_V) begin
            n_err++;
            $display("FAIL reset_idle: got %h expected %h", obs_vec(), IDLE_V);
        end
        reset = 1'b0;
        bus.lcd_enable = 1'b0;
        step();
        step();
        n_cmp++;
        if (obs_vec() !== IDLE_V) begin
            n_err++;
            $display("FAIL disabled_idle: got %h expected %h", obs_vec(), IDLE_V);
        end
    endtask

    typedef struct { int dot; logic [1:0] mode; logic oam_ok; logic vram_ok; } spot_t;

    task automatic test_full_frame();
        spot_t spots[6];
        int bad, dl, vb, fd;
        logic [16:0] ev, fo, fe;
        spots[0] = '{0,   2'd2, 1'b0, 1'b1};
        spots[1] = '{79,  2'd2, 1'b0, 1'b1};
        spots[2] = '{80,  2'd3, 1'b0, 1'b0};
        spots[3] = '{251, 2'd3, 1'b0, 1'b0};
        spots[4] = '{252, 2'd0, 1'b1, 1'b1};
        spots[5] = '{455, 2'd0, 1'b1, 1'b1};
        bad = 0; dl = 0; vb = 0; fd = 0; fo = 17'd0; fe = 17'd0;
        bus.stat_int_en = 4'h0;
        bus.lyc = 8'd200;
        restart();
        for (int c = 0; c < T_DOTS * T_TOTAL; c++) begin
            if (c > 0) step_model();
            ev = model_vec(m_dot, m_ly, 1'b0, 1'b0);
            if (obs_vec() !== ev) begin
                if (bad == 0) begin fo = obs_vec(); fe = ev; end
                bad++;
            end
            dl += int'(bus.drawline);
            vb += int'(bus.vblank_irq);
            fd += int'(bus.frame_done);
            if (m_ly == 0) begin
                for (int s = 0; s < 6; s++) begin
                    if (spots[s].dot == m_dot) begin
                        n_cmp++;
                        if ({bus.mode, bus.oam_cpu_ok, bus.vram_cpu_ok} !==
                            {spots[s].mode, spots[s].oam_ok, spots[s].vram_ok}) begin
                            n_err++;
                            $display("FAIL line0_dot%0d: got mode=%0d oam_ok=%b vram_ok=%b expected mode=%0d oam_ok=%b vram_ok=%b",
                                     m_dot, bus.mode, bus.oam_cpu_ok, bus.vram_cpu_ok,
                                     spots[s].mode, spots[s].oam_ok, spots[s].vram_ok);
                        end
                    end
                end
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL frame_trace: %0d bad cycles, first got %h expected %h", bad, fo, fe);
        end
        n_cmp++;
        if (dl != T_VIS) begin n_err++; $display("FAIL drawline_count: got %0d expected %0d", dl, T_VIS); end
        n_cmp++;
        if (vb != 1) begin n_err++; $display("FAIL vblank_count: got %0d expected 1", vb); end
        n_cmp++;
        if (fd != 1) begin n_err++; $display("FAIL frame_done_count: got %0d expected 1", fd); end
        step_model();
        n_cmp++;
        if ({bus.ly, bus.mode} !== {8'd0, 2'd2}) begin
            n_err++;
            $display("FAIL ly_wrap: got ly=%0d mode=%0d expected ly=0 mode=2", bus.ly, bus.mode);
        end
    endtask

    task automatic test_lyc();
        int bad, pulses;
        logic [16:0] ev, fo, fe;
        bad = 0; pulses = 0; fo = 17'd0; fe = 17'd0;
        bus.stat_int_en = 4'b1000;
        bus.lyc = 8'd10;
        restart();
        for (int c = 0; c <= T_DOTS * (T_TOTAL + 10) + 200; c++) begin
            if (c > 0) step_model();
            ev = model_vec(m_dot, m_ly, (m_ly == 10), (m_ly == 10 && m_dot == 0));
            if (obs_vec() !== ev) begin
                if (bad == 0) begin fo = obs_vec(); fe = ev; end
                bad++;
            end
            pulses += int'(bus.stat_irq);
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL lyc_trace: %0d bad cycles, first got %h expected %h", bad, fo, fe);
        end
        n_cmp++;
        if (pulses != 2) begin n_err++; $display("FAIL lyc_pulse_count: got %0d expected 2", pulses); end
        bus.lyc = 8'd11;
        step_model();
        n_cmp++;
        if ({bus.lyc_match, bus.stat_irq} !== 2'b00) begin
            n_err++;
            $display("FAIL lyc_write_off: got match=%b irq=%b expected match=0 irq=0", bus.lyc_match, bus.stat_irq);
        end
        bus.lyc = 8'd10;
        step_model();
        n_cmp++;
        if ({bus.lyc_match, bus.stat_irq} !== 2'b11) begin
            n_err++;
            $display("FAIL lyc_write_on: got match=%b irq=%b expected match=1 irq=1", bus.lyc_match, bus.stat_irq);
        end
    endtask

    task automatic test_back_to_back();
        int bad, pulses;
        logic [16:0] ev, fo, fe;
        bad = 0; pulses = 0; fo = 17'd0; fe = 17'd0;
        bus.stat_int_en = 4'b0101;
        bus.lyc = 8'd200;
        restart();
        for (int c = 0; c < T_DOTS * T_TOTAL; c++) begin
            if (c > 0) step_model();
            ev = model_vec(m_dot, m_ly, 1'b0,
                           (m_ly == 0 && m_dot == 0) || (m_dot == 252 && m_ly < T_VIS));
            if (obs_vec() !== ev) begin
                if (bad == 0) begin fo = obs_vec(); fe = ev; end
                bad++;
            end
            pulses += int'(bus.stat_irq);
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL b2b_trace: %0d bad cycles, first got %h expected %h", bad, fo, fe);
        end
        n_cmp++;
        if (pulses != T_VIS + 1) begin
            n_err++;
            $display("FAIL b2b_pulse_count: got %0d expected %0d", pulses, T_VIS + 1);
        end
        step_model();
        n_cmp++;
        if ({bus.ly, bus.mode, bus.stat_irq} !== {8'd0, 2'd2, 1'b1}) begin
            n_err++;
            $display("FAIL vblank_to_oam_irq: got ly=%0d mode=%0d irq=%b expected ly=0 mode=2 irq=1",
                     bus.ly, bus.mode, bus.stat_irq);
        end
    endtask

    task automatic test_enable_drop();
        bus.stat_int_en = 4'b1111;
        bus.lyc = 8'd12;
        restart();
        for (int c = 0; c < 12 * T_DOTS + 120; c++) step_model();
        n_cmp++;
        if ({bus.ly, bus.mode, bus.lyc_match} !== {8'd12, 2'd3, 1'b1}) begin
            n_err++;
            $display("FAIL drop_pre: got ly=%0d mode=%0d match=%b expected ly=12 mode=3 match=1",
                     bus.ly, bus.mode, bus.lyc_match);
        end
        bus.lcd_enable = 1'b0;
        step();
        n_cmp++;
        if (obs_vec() !== IDLE_V) begin
            n_err++;
            $display("FAIL drop_idle: got %h expected %h", obs_vec(), IDLE_V);
        end
        step();
        step();
        n_cmp++;
        if (obs_vec() !== IDLE_V) begin
            n_err++;
            $display("FAIL drop_hold: got %h expected %h", obs_vec(), IDLE_V);
        end
        bus.lcd_enable = 1'b1;
        step();
        m_dot = 0;
        m_ly  = 0;
        n_cmp++;
        if (obs_vec() !== {1'b0, 8'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reenable: got %h expected %h", obs_vec(),
                     {1'b0, 8'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        for (int c = 0; c < 79; c++) step_model();
        bus.lcd_enable = 1'b0;
        step();
        n_cmp++;
        if (obs_vec() !== IDLE_V) begin
            n_err++;
            $display("FAIL drop_before_drawline: got %h expected %h", obs_vec(), IDLE_V);
        end
    endtask

    task automatic test_reset_midline();
        bus.stat_int_en = 4'b0101;
        bus.lyc = 8'd200;
        restart();
        for (int c = 0; c < 14 * T_DOTS + 300; c++) step_model();
        n_cmp++;
        if ({bus.ly, bus.mode} !== {8'd14, 2'd0}) begin
            n_err++;
            $display("FAIL reset_pre: got ly=%0d mode=%0d expected ly=14 mode=0", bus.ly, bus.mode);
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if (obs_vec() !== IDLE_V) begin
            n_err++;
            $display("FAIL reset_mid: got %h expected %h", obs_vec(), IDLE_V);
        end
        reset = 1'b0;
        step();
        m_dot = 0;
        m_ly  = 0;
        n_cmp++;
        if (obs_vec() !== {1'b0, 8'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_resume: got %h expected %h", obs_vec(),
                     {1'b0, 8'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        for (int c = 0; c < 80; c++) step_model();
        n_cmp++;
        if (obs_vec() !== {1'b1, 8'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL resume_drawline: got %h expected %h", obs_vec(),
                     {1'b1, 8'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_dot = 0;
        m_ly  = 0;
        reset = 1'b1;
        bus.lcd_enable  = 1'b0;
        bus.lyc         = 8'd0;
        bus.stat_int_en = 4'h0;
        test_reset();
        test_full_frame();
        test_lyc();
        test_back_to_back();
        test_enable_drop();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
